// File: rtl/alu_result_sender_pkg.sv
// Shared types for the ALU_out result sender: strobe FSM states and pointer sizing.
// Imported by the FIFO and the top-level sender.
package alu_result_sender_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STROBE = 2'd1,
        GAP    = 2'd2
    } state_t;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/alu_result_sender_if.sv
// ALU_out result bus: datapath-side valid/ready push plus done/result strobe and occupancy.
// master = the sender block, slave = whoever feeds results and watches the strobe.
interface alu_result_sender_if #(
    parameter int WIDTH   = 16,
    parameter int LEVEL_W = 3
);
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_result;
    logic               done;
    logic [WIDTH-1:0]   result;
    logic [LEVEL_W-1:0] level;

    modport master (
        input  in_valid, in_result,
        output in_ready, done, result, level
    );

    modport slave (
        output in_valid, in_result,
        input  in_ready, done, result, level
    );
endinterface

// File: rtl/alu_result_fifo.sv
// Synchronous power-of-two FIFO with registered occupancy; head is read combinationally.
// Push is ignored when full and pop when empty; full does not account for a same-cycle pop.
module alu_result_fifo
    import alu_result_sender_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic [WIDTH-1:0]       push_data,
    input  logic                   pop,
    output logic [WIDTH-1:0]       head,
    output logic                   full,
    output logic                   empty,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PW = ptr_width(DEPTH);
    localparam int LW = $clog2(DEPTH) + 1;
    localparam logic [LW-1:0] FULL_LEVEL = LW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == FULL_LEVEL);
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Pointers are exactly log2(DEPTH) bits, so natural overflow is the modulo wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/alu_result_sender.sv
// Buffers ALU results and strobes each on done/result one cycle after it is queued, spaced by DONE_GAP idle cycles.
// in_ready = !full (no pop lookahead); ALU_OUT_RESULT_HOLD_EN keeps result stable between strobes, else it is zeroed.
module alu_result_sender
    import alu_result_sender_pkg::*;
#(
    parameter int ALU_OUT_RESULT_WIDTH = 16,
    parameter int FIFO_DEPTH           = 4,
    parameter int DONE_GAP             = 1
) (
    input  logic                clk,
    input  logic                rst,
    alu_result_sender_if.master bus
);
    localparam int LW = $clog2(FIFO_DEPTH) + 1;
    localparam int CW = (DONE_GAP > 1) ? $clog2(DONE_GAP) : 1;

    state_t                          state, state_nxt;
    logic                            done_q, done_nxt;
    logic [ALU_OUT_RESULT_WIDTH-1:0] result_q, result_nxt;
    logic [CW-1:0]                   gap_cnt, gap_cnt_nxt;
    logic                            launch;
    logic                            pop;
    logic [ALU_OUT_RESULT_WIDTH-1:0] head;
    logic                            full;
    logic                            empty;
    logic [LW-1:0]                   level;

    alu_result_fifo #(
        .WIDTH (ALU_OUT_RESULT_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (bus.in_valid),
        .push_data (bus.in_result),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (level)
    );

    // The last gap cycle launches directly so the strobe period is exactly 1+DONE_GAP.
    always_comb begin
        state_nxt   = state;
        gap_cnt_nxt = gap_cnt;
        launch      = 1'b0;
        pop         = 1'b0;
        done_nxt    = 1'b0;
`ifdef ALU_OUT_RESULT_HOLD_EN
        result_nxt  = result_q;
`else
        result_nxt  = '0;
`endif
        case (state)
            IDLE: begin
                if (!empty) launch = 1'b1;
            end
            STROBE: begin
                if (DONE_GAP == 0 && !empty) begin
                    launch = 1'b1;
                end else if (DONE_GAP > 0) begin
                    gap_cnt_nxt = CW'(DONE_GAP - 1);
                    state_nxt   = GAP;
                end else begin
                    state_nxt = IDLE;
                end
            end
            GAP: begin
                if (gap_cnt != '0)  gap_cnt_nxt = gap_cnt - 1'b1;
                else if (!empty)    launch      = 1'b1;
                else                state_nxt   = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (launch) begin
            pop        = 1'b1;
            done_nxt   = 1'b1;
            result_nxt = head;
            state_nxt  = STROBE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            done_q   <= 1'b0;
            result_q <= '0;
            gap_cnt  <= '0;
        end else begin
            state    <= state_nxt;
            done_q   <= done_nxt;
            result_q <= result_nxt;
            gap_cnt  <= gap_cnt_nxt;
        end
    end

    assign bus.done     = done_q;
    assign bus.result   = result_q;
    assign bus.in_ready = !full;
    assign bus.level    = level;

endmodule
